// File: rtl/nco_mix_dump_if.sv
// Sample/result bus of the NCO mixer + integrate-and-dump stage.
// Handshake: a sample moves only in an enabled cycle where adc_valid_i and
// nco_valid_i are both high (there is no ready; the stage never stalls the
// source). acc_valid_o marks a fresh acc_o for exactly one enabled cycle.
interface nco_mix_dump_if #(
  parameter int mpr = 13,
  parameter int adw = 14,
  parameter int ow  = 32,
  parameter int lw  = 16
);
  logic [mpr-1:0] fsin_i;
  logic           nco_valid_i;
  logic [adw-1:0] adc_i;
  logic           adc_valid_i;
  logic           sync_i;
  logic [lw-1:0]  dump_len_i;
  logic [ow-1:0]  acc_o;
  logic           acc_valid_o;
  logic           ovf_o;
  logic [lw-1:0]  frame_cnt_o;

  modport master (
    output fsin_i, nco_valid_i, adc_i, adc_valid_i, sync_i, dump_len_i,
    input  acc_o, acc_valid_o, ovf_o, frame_cnt_o
  );

  modport slave (
    input  fsin_i, nco_valid_i, adc_i, adc_valid_i, sync_i, dump_len_i,
    output acc_o, acc_valid_o, ovf_o, frame_cnt_o
  );
endinterface

// File: rtl/nco_mix_dump.sv
// Mixes ADC samples with the NCO sine, integrates the products over a
// sweep-aligned window and emits one saturated result per window.
module nco_mix_dump #(
  parameter int mpr = 13,
  parameter int adw = 14,
  parameter int ow  = 32,
  parameter int lw  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clken,
  nco_mix_dump_if.slave bus,
  output logic [0:0]    dbg_state
);

  localparam int pw = adw + mpr;

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_run  = 1'b1;

  logic [0:0]           state;
  logic [lw-1:0]        len_q;
  logic [lw-1:0]        cnt;
  logic signed [pw-1:0] p1;
  logic                 v1;
  logic [ow-1:0]        acc;
  logic [ow-1:0]        acc_out;
  logic                 acc_valid;
  logic                 ovf;
  logic [lw-1:0]        frame_cnt;

  logic                 sync;
  logic                 accept;
  logic [lw-1:0]        len_m1;
  logic                 last;
  logic [ow:0]          sum;
  logic                 sat_hit;
  logic [ow-1:0]        sum_sat;

  assign sync   = bus.sync_i;
  // A sync cycle's own sample already belongs to the new window.
  assign accept = bus.adc_valid_i & bus.nco_valid_i & ((state == st_run) | sync);
  assign len_m1 = len_q - lw'(1);
  assign last   = (cnt == len_m1);

  // One guard bit above the accumulator detects two's complement overflow.
  always_comb begin
    sum     = {acc[ow-1], acc} + {{(ow + 1 - pw){p1[pw-1]}}, p1};
    sat_hit = sum[ow] ^ sum[ow-1];
    sum_sat = sum[ow-1:0];
    if (sat_hit) begin
      sum_sat = sum[ow] ? {1'b1, {(ow - 1){1'b0}}} : {1'b0, {(ow - 1){1'b1}}};
    end
  end

  // Sweep state and window length; a zero length behaves as one sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= st_idle;
      len_q <= lw'(1);
    end else if (clken && sync) begin
      state <= st_run;
      len_q <= (bus.dump_len_i == '0) ? lw'(1) : bus.dump_len_i;
    end
  end

  // Stage 1: registered full-precision product with its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1 <= '0;
      v1 <= 1'b0;
    end else if (clken) begin
      p1 <= $signed(bus.adc_i) * $signed(bus.fsin_i);
      v1 <= accept;
    end
  end

  // Stage 2: accumulate, saturate and dump; sync discards the old product.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
      frame_cnt <= '0;
    end else if (clken) begin
      acc_valid <= 1'b0;
      if (sync) begin
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
        frame_cnt <= '0;
      end else if (v1) begin
        if (sat_hit) begin
          ovf <= 1'b1;
        end
        if (last) begin
          acc_out   <= sum_sat;
          acc_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          frame_cnt <= frame_cnt + lw'(1);
        end else begin
          acc <= sum_sat;
          cnt <= cnt + lw'(1);
        end
      end
    end
  end

  assign bus.acc_o       = acc_out;
  assign bus.acc_valid_o = acc_valid;
  assign bus.ovf_o       = ovf;
  assign bus.frame_cnt_o = frame_cnt;
  assign dbg_state       = state;

endmodule

// File: tb/tb_nco_mix_dump.sv
// Directed bench for nco_mix_dump: two instances (ow=32 and ow=27) share the
// same stimulus; a monitor pops expected dumps and checks value and timing.
module tb_nco_mix_dump;

  logic        clk;
  logic        reset;
  logic        clken;
  logic        adc_valid;
  logic        nco_valid;
  logic        sync;
  logic [13:0] adc;
  logic [12:0] fsin;
  logic [15:0] dump_len;
  logic [0:0]  state_a;
  logic [0:0]  state_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // {acc (32, sign-extended), frame_cnt (16), ovf (1)}
  logic [48:0] exp_a[$];
  logic [48:0] exp_b[$];
  int          due_a[$];
  int          due_b[$];

  nco_mix_dump_if #(.ow(32)) bus_a ();
  nco_mix_dump_if #(.ow(27)) bus_b ();

  assign bus_a.fsin_i      = fsin;
  assign bus_a.nco_valid_i = nco_valid;
  assign bus_a.adc_i       = adc;
  assign bus_a.adc_valid_i = adc_valid;
  assign bus_a.sync_i      = sync;
  assign bus_a.dump_len_i  = dump_len;
  assign bus_b.fsin_i      = fsin;
  assign bus_b.nco_valid_i = nco_valid;
  assign bus_b.adc_i       = adc;
  assign bus_b.adc_valid_i = adc_valid;
  assign bus_b.sync_i      = sync;
  assign bus_b.dump_len_i  = dump_len;

  nco_mix_dump #(.ow(32)) dut_a (
    .clk(clk), .reset(reset), .clken(clken), .bus(bus_a), .dbg_state(state_a)
  );

  nco_mix_dump #(.ow(27)) dut_b (
    .clk(clk), .reset(reset), .clken(clken), .bus(bus_b), .dbg_state(state_b)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of stimulus
  task automatic drive(input bit en, input bit val, input int a, input int f,
                       input bit s, input int len);
    @(posedge clk);
    #1;
    clken     = en;
    adc_valid = val;
    nco_valid = val;
    adc       = a[13:0];
    fsin      = f[12:0];
    sync      = s;
    dump_len  = len[15:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
  endtask

  // called in the cycle of a window's last sample; dump is due 2 enabled cycles later
  task automatic expect_dump(input longint acc_a, input bit ovf_a,
                             input longint acc_b, input bit ovf_b, input int frame);
    exp_a.push_back({acc_a[31:0], frame[15:0], ovf_a});
    exp_b.push_back({acc_b[31:0], frame[15:0], ovf_b});
    due_a.push_back(cyc + 2);
    due_b.push_back(cyc + 2);
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // scoreboard monitor: consumers look at outputs only on enabled cycles
  always @(negedge clk) begin
    logic [48:0] got, e;
    int d;
    if (clken && !reset) begin
      if (bus_a.acc_valid_o) begin
        got = {bus_a.acc_o, bus_a.frame_cnt_o, bus_a.ovf_o};
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL dump_a unexpected acc=%0d", $signed(bus_a.acc_o));
        end else begin
          e = exp_a.pop_front();
          d = due_a.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL dump_a got acc=%0d frame=%0d ovf=%0d exp acc=%0d frame=%0d ovf=%0d",
                     $signed(got[48:17]), got[16:1], got[0], $signed(e[48:17]), e[16:1], e[0]);
          end
          checks++;
          if (cyc != d) begin
            errors++;
            $display("FAIL time_a got cycle %0d exp cycle %0d", cyc, d);
          end
        end
      end
      if (bus_b.acc_valid_o) begin
        got = {{5{bus_b.acc_o[26]}}, bus_b.acc_o, bus_b.frame_cnt_o, bus_b.ovf_o};
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL dump_b unexpected acc=%0d", $signed(bus_b.acc_o));
        end else begin
          e = exp_b.pop_front();
          d = due_b.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL dump_b got acc=%0d frame=%0d ovf=%0d exp acc=%0d frame=%0d ovf=%0d",
                     $signed(got[48:17]), got[16:1], got[0], $signed(e[48:17]), e[16:1], e[0]);
          end
          checks++;
          if (cyc != d) begin
            errors++;
            $display("FAIL time_b got cycle %0d exp cycle %0d", cyc, d);
          end
        end
      end
    end
    if (clken) cyc++;
  end

  initial begin
    reset = 1'b1; clken = 1'b1; adc_valid = 1'b0; nco_valid = 1'b0;
    sync = 1'b0; adc = '0; fsin = '0; dump_len = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_acc_a", bus_a.acc_o, 0);
    chk("rst_acc_b", bus_b.acc_o, 0);
    chk("rst_valid_a", bus_a.acc_valid_o, 0);
    chk("rst_ovf_a", bus_a.ovf_o, 0);
    chk("rst_frame_a", bus_a.frame_cnt_o, 0);
    chk("rst_state_a", state_a, 0);

    // IDLE ignores samples without sync
    repeat (20) drive(1'b1, 1'b1, 123, -45, 1'b0, 7);
    idle(3);
    @(negedge clk);
    chk("idle_acc_a", bus_a.acc_o, 0);
    chk("idle_frame_a", bus_a.frame_cnt_o, 0);
    chk("idle_ovf_b", bus_b.ovf_o, 0);
    chk("idle_state_a", state_a, 0);

    // basic window: 4 x 100*50
    drive(1'b1, 1'b1, 100, 50, 1'b1, 4);
    drive(1'b1, 1'b1, 100, 50, 1'b0, 4);
    drive(1'b1, 1'b1, 100, 50, 1'b0, 4);
    drive(1'b1, 1'b1, 100, 50, 1'b0, 4);
    expect_dump(20000, 1'b0, 20000, 1'b0, 1);
    idle(3);
    @(negedge clk);
    chk("basic_state_a", state_a, 1);

    // sign and continuous flow, length 2
    drive(1'b1, 1'b1, -3, 7, 1'b1, 2);
    drive(1'b1, 1'b1, 5, -2, 1'b0, 0);
    expect_dump(-31, 1'b0, -31, 1'b0, 1);
    drive(1'b1, 1'b1, 1, 1, 1'b0, 0);
    drive(1'b1, 1'b1, -1, 1, 1'b0, 0);
    expect_dump(0, 1'b0, 0, 1'b0, 2);
    idle(3);
    @(negedge clk);
    chk("flow_frame_a", bus_a.frame_cnt_o, 2);

    // saturation: 16 x 2^25 fits ow=32, clips ow=27 at 2^26-1
    drive(1'b1, 1'b1, -8192, -4096, 1'b1, 16);
    repeat (15) drive(1'b1, 1'b1, -8192, -4096, 1'b0, 16);
    expect_dump(536870912, 1'b0, 67108863, 1'b1, 1);
    idle(5);
    @(negedge clk);
    chk("sat_ovf_b_sticky", bus_b.ovf_o, 1);
    chk("sat_ovf_a", bus_a.ovf_o, 0);
    drive(1'b1, 1'b0, 0, 0, 1'b1, 1);
    idle(1);
    @(negedge clk);
    chk("sat_ovf_b_cleared", bus_b.ovf_o, 0);
    chk("sat_frame_b_cleared", bus_b.frame_cnt_o, 0);

    // sync mid-window with length 0
    drive(1'b1, 1'b1, 1, 1, 1'b1, 8);
    repeat (4) drive(1'b1, 1'b1, 1, 1, 1'b0, 8);
    drive(1'b1, 1'b1, 2, 3, 1'b1, 0);
    expect_dump(6, 1'b0, 6, 1'b0, 1);
    idle(3);
    @(negedge clk);
    chk("len0_frame_a", bus_a.frame_cnt_o, 1);

    // sync beats a pending dump, then back-to-back length-1 windows;
    // dump_len changes without sync are ignored
    drive(1'b1, 1'b1, 1, 1, 1'b1, 2);
    drive(1'b1, 1'b1, 1, 1, 1'b0, 2);
    drive(1'b1, 1'b1, 4, 4, 1'b1, 1);
    expect_dump(16, 1'b0, 16, 1'b0, 1);
    drive(1'b1, 1'b1, 2, 2, 1'b0, 5);
    expect_dump(4, 1'b0, 4, 1'b0, 2);
    drive(1'b1, 1'b1, 3, 3, 1'b0, 5);
    expect_dump(9, 1'b0, 9, 1'b0, 3);
    drive(1'b1, 1'b1, -1, 5, 1'b0, 5);
    expect_dump(-5, 1'b0, -5, 1'b0, 4);
    idle(3);

    // reset with a dump pending, then samples without sync
    drive(1'b1, 1'b1, 7, 7, 1'b1, 2);
    drive(1'b1, 1'b1, 7, 7, 1'b0, 2);
    @(posedge clk);
    #1 reset = 1'b1; adc_valid = 1'b0; nco_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) drive(1'b1, 1'b1, 7, 7, 1'b0, 2);
    idle(3);
    @(negedge clk);
    chk("midrst_acc_a", bus_a.acc_o, 0);
    chk("midrst_frame_a", bus_a.frame_cnt_o, 0);
    chk("midrst_state_a", state_a, 0);

    // clken gating: disabled cycles carry junk and a sync that must be ignored
    drive(1'b1, 1'b1, 100, 50, 1'b1, 4);
    drive(1'b0, 1'b1, 9, 9, 1'b1, 9);
    drive(1'b1, 1'b1, 100, 50, 1'b0, 4);
    drive(1'b0, 1'b1, 9, 9, 1'b1, 9);
    drive(1'b1, 1'b1, 100, 50, 1'b0, 4);
    drive(1'b0, 1'b1, 9, 9, 1'b1, 9);
    drive(1'b1, 1'b1, 100, 50, 1'b0, 4);
    expect_dump(20000, 1'b0, 20000, 1'b0, 1);
    drive(1'b0, 1'b1, 9, 9, 1'b1, 9);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
    drive(1'b0, 1'b1, 9, 9, 1'b1, 9);
    @(negedge clk);
    chk("gate_hold_valid_a", bus_a.acc_valid_o, 1);
    chk("gate_hold_acc_a", bus_a.acc_o, 20000);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
    drive(1'b0, 1'b1, 9, 9, 1'b1, 9);
    @(negedge clk);
    chk("gate_after_valid_a", bus_a.acc_valid_o, 0);
    chk("gate_frame_a", bus_a.frame_cnt_o, 1);

    // drain
    idle(4);
    @(negedge clk);
    chk("drain_a", exp_a.size(), 0);
    chk("drain_b", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
